// File: rtl/fpga_ram_bytelane.sv
// Byte-lane RAM built on inferred FPGA block RAM, any width 8/16/32/64 and any depth.
// Optional post-reset clear sweep (READY low while it runs), optional output register,
// RVALID strobe for every completed read.
// Build option: define FPGA_RAM_PARITY_EN to store an even-parity bit per lane, add the PINJ
// input for parity injection and report mismatches on PERR; otherwise PERR is tied low.
module fpga_ram_bytelane #(
  parameter int unsigned AW             = 16,
  parameter int unsigned DW             = 32,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned LW            = $clog2(DW / 8)
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [AW-LW-1:0]    ADDR,
  input  logic [DW-1:0]       WDATA,
  input  logic [DW/8-1:0]     WREN,
  input  logic                CS,
`ifdef FPGA_RAM_PARITY_EN
  input  logic                PINJ,
`endif
  output logic [DW-1:0]       RDATA,
  output logic                RVALID,
  output logic                READY,
  output logic                PERR
);

  localparam int unsigned NL    = DW / 8;
  localparam int unsigned CW    = AW - LW;
  localparam int unsigned Depth = 2 ** CW;

  if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64)) begin : g_bad_dw
    $error("fpga_ram_bytelane: DW must be 8, 16, 32 or 64");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            ready_q;

  logic [DW-1:0]   mem_q [Depth];

  logic            clearing;
  logic            wr_en;
  logic            rd_en;
  logic [NL-1:0]   lane_we;
  logic [CW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;

  logic [DW-1:0]   rd1_q;
  logic            rv1_q;
  logic            perr1;

  // Clear-sweep sequencer; READY rises together with the move to StRun
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= (CLEAR_ON_RESET != 0) ? StInit : StRun;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun:   ready_q <= 1'b1;
        default: state_q <= StRun;
      endcase
    end
  end

  // Access decode: the sweep owns the write port, writes win over reads
  always_comb begin
    clearing  = (state_q == StInit);
    wr_en     = ready_q & CS & (|WREN);
    rd_en     = ready_q & CS & ~(|WREN);
    lane_we   = clearing ? {NL{1'b1}} : (wr_en ? WREN : '0);
    mem_addr  = clearing ? cnt_q : ADDR;
    mem_wdata = clearing ? '0 : WDATA;
  end

  // Write port, deliberately without reset so it maps onto block RAM
  always_ff @(posedge CLK) begin
    for (int n = 0; n < NL; n++) begin
      if (lane_we[n]) mem_q[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
    end
  end

`ifdef FPGA_RAM_PARITY_EN
  logic [NL-1:0] par_q [Depth];
  logic [NL-1:0] rp1_q;

  // Parity store; PINJ flips the stored bit of each written lane (never during the sweep)
  always_ff @(posedge CLK) begin
    for (int n = 0; n < NL; n++) begin
      if (lane_we[n]) par_q[mem_addr][n] <= (^mem_wdata[8*n +: 8]) ^ (PINJ & ~clearing);
    end
  end

  // Parity bits follow the read data through stage 1
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) rp1_q <= '0;
    else if (rd_en) rp1_q <= par_q[ADDR];
  end

  // Any lane whose recomputed parity disagrees with the stored bit flags an error
  always_comb begin
    perr1 = 1'b0;
    for (int n = 0; n < NL; n++) begin
      if ((^rd1_q[8*n +: 8]) != rp1_q[n]) perr1 = 1'b1;
    end
    perr1 = perr1 & rv1_q;
  end
`else
  assign perr1 = 1'b0;
`endif

  // Read stage 1; data holds between reads, reset drops any read in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rv1_q <= rd_en;
      if (rd_en) rd1_q <= mem_q[ADDR];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] rd2_q;
    logic          rv2_q;
    logic          pe2_q;

    // Optional second stage, loads only when stage 1 carries fresh data
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
        pe2_q <= 1'b0;
      end else begin
        rv2_q <= rv1_q;
        pe2_q <= perr1;
        if (rv1_q) rd2_q <= rd1_q;
      end
    end

    assign RDATA  = rd2_q;
    assign RVALID = rv2_q;
    assign PERR   = pe2_q;
  end else begin : g_no_out_reg
    assign RDATA  = rd1_q;
    assign RVALID = rv1_q;
    assign PERR   = perr1;
  end

  assign READY = ready_q;

endmodule

// File: tb/tb_fpga_ram_bytelane.sv
// Bench for fpga_ram_bytelane: one instance per read latency, shared stimulus, word-array
// reference model with read results delayed by the documented latency.
module tb_fpga_ram_bytelane;

  localparam int unsigned Depth = 16384;

  logic        clk;
  logic        rst_n;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wren;
  logic        cs;
  logic        pinj;

  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, ready0, ready1, perr0, perr1;

  fpga_ram_bytelane #(.AW(16), .DW(32), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .CLK    (clk),
    .RESETn (rst_n),
    .ADDR   (addr),
    .WDATA  (wdata),
    .WREN   (wren),
    .CS     (cs),
`ifdef FPGA_RAM_PARITY_EN
    .PINJ   (pinj),
`endif
    .RDATA  (rdata0),
    .RVALID (rvalid0),
    .READY  (ready0),
    .PERR   (perr0)
  );

  fpga_ram_bytelane #(.AW(16), .DW(32), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .CLK    (clk),
    .RESETn (rst_n),
    .ADDR   (addr),
    .WDATA  (wdata),
    .WREN   (wren),
    .CS     (cs),
`ifdef FPGA_RAM_PARITY_EN
    .PINJ   (pinj),
`endif
    .RDATA  (rdata1),
    .RVALID (rvalid1),
    .READY  (ready1),
    .PERR   (perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mem_m [Depth];
  logic [3:0]  inj_m [Depth];
  logic        ready_m;
  // Expected outputs: latency-1 instance (e0_*), latency-2 instance (e1_*), in-flight slot (p_*)
  logic        e0_v, e0_p, e1_v, e1_p, p_v, p_p;
  logic [31:0] e0_d, e1_d, p_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_expect();
    e0_v = 0; e0_p = 0; e0_d = '0;
    e1_v = 0; e1_p = 0; e1_d = '0;
    p_v  = 0; p_p  = 0; p_d  = '0;
  endtask

  // One access cycle: drive at the negedge, model the edge, compare at the next negedge
  task automatic step(input logic c, input logic [3:0] we, input logic [13:0] a,
                      input logic [31:0] d, input logic inj);
    logic        rd, wr, rp;
    logic [31:0] mask, rv;
`ifndef FPGA_RAM_PARITY_EN
    inj = 1'b0;
`endif
    cs = c; wren = we; addr = a; wdata = d; pinj = inj;
    @(posedge clk);
    rd = ready_m && c && (we == 4'd0);
    wr = ready_m && c && (we != 4'd0);
    rv = mem_m[a];
    rp = |inj_m[a];
    e1_v = p_v;
    e1_p = p_p;
    if (p_v) e1_d = p_d;
    p_v = rd; p_p = rd & rp; p_d = rv;
    e0_v = rd; e0_p = rd & rp;
    if (rd) e0_d = rv;
    if (wr) begin
      mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
      mem_m[a] = (mem_m[a] & ~mask) | (d & mask);
      for (int n = 0; n < 4; n++) if (we[n]) inj_m[a][n] = inj;
    end
    @(negedge clk);
    check("rvalid0", {63'd0, rvalid0}, {63'd0, e0_v});
    check("rdata0",  {32'd0, rdata0},  {32'd0, e0_d});
    check("perr0",   {63'd0, perr0},   {63'd0, e0_p});
    check("rvalid1", {63'd0, rvalid1}, {63'd0, e1_v});
    check("rdata1",  {32'd0, rdata1},  {32'd0, e1_d});
    check("perr1",   {63'd0, perr1},   {63'd0, e1_p});
    check("ready",   {62'd0, ready1, ready0}, {62'd0, ready_m, ready_m});
  endtask

  // Async reset asserted between edges; outputs must clear at once; released at a negedge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    check("rst_ready",  {62'd0, ready1, ready0},   64'd0);
    check("rst_rdata",  {rdata1, rdata0},          64'd0);
    check("rst_perr",   {62'd0, perr1, perr0},     64'd0);
    ready_m = 1'b0;
    clear_expect();
    repeat (2) @(negedge clk);
    check("rst_hold_rvalid", {62'd0, rvalid1, rvalid0}, 64'd0);
    rst_n = 1'b1;
  endtask

  // Count cycles from reset release to READY while hammering reads that must be ignored
  task automatic do_sweep();
    int   k;
    logic rv_seen;
    k = 0;
    rv_seen = 1'b0;
    while (k < Depth + 8) begin
      cs = 1'b1; wren = 4'd0; addr = 14'($urandom); wdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      k++;
      rv_seen = rv_seen | rvalid0 | rvalid1;
      if (ready0) break;
    end
    check("sweep_len", 64'(k), 64'(Depth));
    check("sweep_ready1", {63'd0, ready1}, 64'd1);
    check("sweep_no_rvalid", {63'd0, rv_seen}, 64'd0);
    for (int i = 0; i < Depth; i++) begin
      mem_m[i] = '0;
      inj_m[i] = '0;
    end
    ready_m = 1'b1;
  endtask

  initial begin
    logic        rv_seen;
    logic [31:0] v [1:3];
    rst_n = 1'b1; cs = 0; wren = 0; addr = 0; wdata = 0; pinj = 0;
    ready_m = 0;
    clear_expect();
    @(negedge clk);
    do_reset();

    // Partial sweep up to word 100 with reads attempted, then reset restarts it
    rv_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cs = 1'b1; wren = 4'd0; addr = 14'($urandom);
      @(posedge clk);
      @(negedge clk);
      rv_seen = rv_seen | rvalid0 | rvalid1;
    end
    check("init_no_rvalid", {63'd0, rv_seen}, 64'd0);
    check("init_ready_low", {62'd0, ready1, ready0}, 64'd0);
    do_reset();
    do_sweep();

    // Top word reads back cleared
    step(1, 4'h0, 14'h3FFF, 32'h0, 0);
    check("top_word", {32'd0, rdata0}, 64'h0);
    step(0, 4'h0, 14'h0, 32'h0, 0);

    // Full write, single-lane merge, read back
    step(1, 4'hF, 14'h0010, 32'hDEADBEEF, 0);
    step(1, 4'b0100, 14'h0010, 32'h00AA0000, 0);
    step(1, 4'h0, 14'h0010, 32'h0, 0);
    check("lane_merge", {31'd0, rvalid0, rdata0}, {31'd0, 1'b1, 32'hDEAABEEF});
    step(0, 4'h0, 14'h0, 32'h0, 0);

    // Read immediately after write of the same word
    step(1, 4'hF, 14'h0020, 32'h12345678, 0);
    step(1, 4'h0, 14'h0020, 32'h0, 0);
    check("raw_next", {32'd0, rdata0}, 64'h12345678);
    step(0, 4'h0, 14'h0, 32'h0, 0);

    // Back-to-back reads of words 1..3
    for (int i = 1; i <= 3; i++) begin
      v[i] = $urandom;
      step(1, 4'hF, 14'(i), v[i], 0);
    end
    for (int i = 1; i <= 3; i++) step(1, 4'h0, 14'(i), 32'h0, 0);
    check("b2b_last0", {32'd0, rdata0}, {32'd0, v[3]});
    step(0, 4'h0, 14'h0, 32'h0, 0);
    check("b2b_last1", {31'd0, rvalid1, rdata1}, {31'd0, 1'b1, v[3]});
    step(0, 4'h0, 14'h0, 32'h0, 0);

`ifdef FPGA_RAM_PARITY_EN
    step(1, 4'b0001, 14'h0005, 32'h01020304, 1);
    step(1, 4'h0, 14'h0005, 32'h0, 0);
    check("perr_inj", {62'd0, rvalid0, perr0}, 64'd3);
    step(0, 4'h0, 14'h0, 32'h0, 0);
    check("perr_inj1", {62'd0, rvalid1, perr1}, 64'd3);
    step(1, 4'b0001, 14'h0005, 32'h01020304, 0);
    step(1, 4'h0, 14'h0005, 32'h0, 0);
    check("perr_clean", {62'd0, rvalid0, perr0}, 64'd2);
    step(0, 4'h0, 14'h0, 32'h0, 0);
`endif

    // Random traffic over a small window so reads and writes collide often
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 2) ? 4'h0 : 4'($urandom % 16),
           14'($urandom % 32), $urandom, 1'($urandom % 2));
    end

    // Reset with a read in flight in the latency-2 instance: it must never appear
    step(1, 4'h0, 14'h0010, 32'h0, 0);
    do_reset();
    do_sweep();
    step(1, 4'h0, 14'h0010, 32'h0, 0);
    check("resweep_word", {32'd0, rdata0}, 64'h0);
    step(0, 4'h0, 14'h0, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
